memory_layer_node_release: RTL

MEMORY_LAYER_NODE_RELEASE -- requirements
Module: memory_layer_node_release

---
 rtl/GAM_package.sv | 20 ++
 rtl/node_max_tree.sv | 19 +
 rtl/memory_layer_node_release.sv | 138 +++++++++++++
 3 files changed

// File: rtl/GAM_package.sv
// Shared defaults, index/count types and the release FSM state encoding
// for the per-class node release block.
package GAM_package;

    localparam int unsigned NUM_CLASSES_DEF = 16;
    localparam int unsigned COUNT_W_DEF     = 16;
    localparam int unsigned REL_W_DEF       = 8;
    localparam int unsigned CLS_W_DEF       = $clog2(NUM_CLASSES_DEF);

    typedef logic [CLS_W_DEF-1:0]   class_idx_t;
    typedef logic [COUNT_W_DEF-1:0] node_count_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        UPDATE = 2'd2,
        RESP   = 2'd3
    } rel_state_e;

endpackage

// File: rtl/node_max_tree.sv
// Combinational maximum over all per-class node counts.
module node_max_tree #(
    parameter int unsigned NUM = 16,
    parameter int unsigned W   = 16
) (
    input  logic [W-1:0] vals_i [NUM],
    output logic [W-1:0] max_o
);

    always_comb begin
        max_o = '0;
        for (int i = 0; i < NUM; i++) begin
            if (vals_i[i] > max_o) begin
                max_o = vals_i[i];
            end
        end
    end

endmodule

// File: rtl/memory_layer_node_release.sv
// Per-class node count table with saturating increments and a handshaked
// release path (IDLE -> READ -> UPDATE -> RESP), plus a registered maximum.
module memory_layer_node_release
    import GAM_package::*;
#(
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int unsigned COUNT_W     = COUNT_W_DEF,
    parameter int unsigned REL_W       = REL_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           inc_en,
    input  logic [$clog2(NUM_CLASSES)-1:0] inc_class,
    input  logic                           rel_valid,
    output logic                           rel_ready,
    input  logic [$clog2(NUM_CLASSES)-1:0] rel_class,
    input  logic [REL_W-1:0]               rel_num,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [COUNT_W-1:0]             rsp_count,
    output logic                           rsp_err,
    output logic [COUNT_W-1:0]             node_max
);

    localparam int unsigned CLS_W = $clog2(NUM_CLASSES);
    localparam int unsigned CMP_W = (COUNT_W > REL_W) ? COUNT_W : REL_W;
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + COUNT_W'(1);
    endfunction

    rel_state_e         state_q;
    logic               rel_ready_q;
    logic               rsp_valid_q;
    logic [COUNT_W-1:0] rsp_count_q;
    logic               rsp_err_q;
    logic [COUNT_W-1:0] node_max_q;
    logic [CLS_W-1:0]   cls_q;
    logic [REL_W-1:0]   num_q;
    logic               oor_q;
    logic [COUNT_W-1:0] hold_q;
    logic [COUNT_W-1:0] hold_d;
    logic [COUNT_W-1:0] table_q [NUM_CLASSES];
    logic [COUNT_W-1:0] table_d [NUM_CLASSES];

    logic               inc_ok_c;
    logic               inc_hit_c;
    logic [COUNT_W-1:0] rd_val_c;
    logic               under_c;
    logic [COUNT_W-1:0] sub_c;
    logic [COUNT_W-1:0] upd_val_c;
    logic [COUNT_W-1:0] max_c;

    // An increment landing on the in-flight class must be folded into it.
    assign inc_ok_c  = inc_en && (32'(inc_class) < NUM_CLASSES);
    assign inc_hit_c = inc_ok_c && (inc_class == cls_q);
    assign rd_val_c  = oor_q ? '0 : table_q[cls_q];
    assign hold_d    = inc_hit_c ? sat_inc(rd_val_c) : rd_val_c;

    assign under_c   = CMP_W'(num_q) > CMP_W'(hold_q);
    assign sub_c     = under_c ? '0 : COUNT_W'(CMP_W'(hold_q) - CMP_W'(num_q));
    assign upd_val_c = inc_hit_c ? sat_inc(sub_c) : sub_c;

    // Release write-back already includes any same-class increment.
    always_comb begin
        table_d = table_q;
        if (inc_ok_c) begin
            table_d[inc_class] = sat_inc(table_q[inc_class]);
        end
        if ((state_q == UPDATE) && !oor_q) begin
            table_d[cls_q] = upd_val_c;
        end
    end

    node_max_tree #(
        .NUM (NUM_CLASSES),
        .W   (COUNT_W)
    ) u_node_max_tree (
        .vals_i (table_q),
        .max_o  (max_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rel_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_count_q <= '0;
            rsp_err_q   <= 1'b0;
            node_max_q  <= '0;
            cls_q       <= '0;
            num_q       <= '0;
            oor_q       <= 1'b0;
            hold_q      <= '0;
            table_q     <= '{default: '0};
        end else begin
            table_q    <= table_d;
            node_max_q <= max_c;
            case (state_q)
                IDLE: begin
                    if (rel_valid && rel_ready_q) begin
                        cls_q       <= rel_class;
                        num_q       <= rel_num;
                        oor_q       <= !(32'(rel_class) < NUM_CLASSES);
                        rel_ready_q <= 1'b0;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    hold_q  <= hold_d;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_count_q <= oor_q ? '0 : upd_val_c;
                    rsp_err_q   <= oor_q | under_c;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rel_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rel_ready = rel_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_count = rsp_count_q;
    assign rsp_err   = rsp_err_q;
    assign node_max  = node_max_q;

endmodule
